multicycle_datapath: RTL and testbench
======================================

// Module: multicycle_datapath
// PURPOSE
//  Multicycle successor of the single-cycle datapath, parametrised in data width and register count.
//  A 5-state sequencer drives one shared memory port through a req/ready handshake.
//  Architectural state: PC, IR, A, B, ALUOut and MDR registers, plus the register file.
//  Control bits come from the external decoder, which decodes the registered IR (instr output).
//  The block sits between that decoder and the unified instruction/data memory.
// PARAMETERS
//  WIDTH    32  datapath/address width; must be >= 32 (the jump field is instr[25:0])
//  REGBITS  5   register-file address bits; 2**REGBITS registers; instr fields are truncated to REGBITS
// PORTS
//  clk         in   1      rising-edge clock
//  reset       in   1      synchronous, active-low reset
//  memtoreg    in   1      writeback source: 1 = MDR, 0 = ALUOut
//  memread     in   1      instruction is a load
//  memwrite    in   1      instruction is a store
//  branch      in   1      instruction is beq
//  jump        in   1      instruction is j
//  alusrc      in   1      ALU srcB: 1 = signimm, 0 = B
//  regdst      in   1      write register: 1 = instr[15:11], 0 = instr[20:16]
//  regwrite    in   1      register write in WB
//  alucontrol  in   3      010 add, 110 sub, 000 and, 001 or, 111 slt (signed); other codes give 0
//  mem_req     out  1      memory access request
//  mem_we      out  1      write qualifier (valid only while mem_req=1)
//  mem_addr    out  WIDTH  word address
//  mem_wdata   out  WIDTH  store data (the B register)
//  mem_rdata   in   WIDTH  read data; valid in the cycle mem_ready=1
//  mem_ready   in   1      access completes in this cycle
//  instr       out  32     IR contents
//  pc          out  WIDTH  program counter
//  state       out  3      FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4
//  zero        out  1      combinational ALU result == 0
//  dbg_addr    in   REGBITS  debug register read address
//  dbg_data    out  WIDTH    combinational register-file read of dbg_addr
// BEHAVIOUR
//  Reset (reset=0 at a clock edge):
//   - state=FETCH, pc=0, IR/A/B/ALUOut/MDR=0.
//   - The register file is not reset; r0 always reads 0 and writes to r0 are ignored.
//  Memory handshake:
//   - mem_req is asserted only in FETCH and MEM.
//   - mem_addr, mem_we and mem_wdata are held stable while mem_req=1 and mem_ready=0.
//   - The FSM leaves FETCH/MEM only in a cycle where mem_ready=1. Zero-wait memory means ready in the first cycle.
//   - mem_ready is ignored outside FETCH and MEM.
//  FETCH:
//   - mem_addr=pc, mem_we=0.
//   - On ready: IR<=mem_rdata, pc<=pc+1, go to DECODE.
//  DECODE:
//   - A<=rf[instr[25:21]], B<=rf[instr[20:16]]; go to EXEC.
//  EXEC: ALUOut<=alu(A, alusrc?signimm:B). signimm = instr[15:0] sign-extended to WIDTH. Next state:
//   - jump: pc<={pc[WIDTH-1:26], instr[25:0]}, go to FETCH (pc here is already the incremented value).
//   - branch: if zero, pc<=pc+signimm; go to FETCH either way.
//   - memread|memwrite: go to MEM.
//   - otherwise: go to WB.
//   - If jump and branch are both set, jump wins. If memread and memwrite are both set, the access is a store.
//  MEM:
//   - mem_addr=ALUOut, mem_we=memwrite.
//   - On ready: a load sets MDR<=mem_rdata and goes to WB; a store goes to FETCH.
//  WB:
//   - If regwrite: rf[regdst?instr[15:11]:instr[20:16]] <= memtoreg?MDR:ALUOut.
//   - Go to FETCH.
//  Latency (zero-wait memory): R-type 4, lw 5, sw 4, beq 3, j 3 cycles. Each memory wait cycle adds 1.
//  Arithmetic:
//   - All adds wrap modulo 2**WIDTH; pc wraps from all-ones to 0.
//   - slt gives 1 or 0, zero-extended to WIDTH.
//  Reset mid-operation (including during a pending FETCH/MEM wait):
//   - The request is dropped in the next cycle; no register-file write or IR update occurs.
//   - Fetching restarts at pc=0.
//  The register file is read in the same state it is written only via dbg_data, which returns the old value.
// TESTING
//  1. Hold reset=0 for 2 cycles, then release -> state=0, pc=0, mem_req=1, mem_addr=0, mem_we=0.
//  2. Preload r1=5, r2=7; fetch add r3,r1,r2 with mem_ready low for 3 cycles -> mem_addr stays 0 and IR is unchanged while waiting; r3=12 exactly 3 cycles after ready; pc=1.
//  3. sw r3,4(r0), then lw r4,4(r0) -> mem_we=1, mem_addr=4, mem_wdata=12 in MEM; r4=12 after WB; lw takes 5 cycles.
//  4. beq r1,r1,-2 at pc=10 -> pc=9; beq r1,r2,-2 at pc=10 -> pc=11; each takes 3 cycles.
//  5. j 0x0000123 at pc=0x20 -> pc=0x123. Write r0 with regwrite=1 -> dbg_data for r0 stays 0.
//  6. Assert reset during a MEM wait of lw r5 -> mem_req=0 on the next cycle; r5 unchanged; pc=0 and state=FETCH.

Source files
------------

// File: rtl/multicycle_datapath_if.sv
// Shared instruction/data memory port between the multicycle datapath and memory.
//   mem_req   : access request (master -> slave)
//   mem_we    : write qualifier, meaningful only while mem_req=1
//   mem_addr  : word address
//   mem_wdata : store data
//   mem_rdata : read data, valid in the cycle mem_ready=1
//   mem_ready : access completes in this cycle
interface multicycle_datapath_if #(
    parameter int unsigned WIDTH = 32
);
    logic             mem_req;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;
    logic             mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/multicycle_datapath.sv
// Multicycle MIPS-style datapath: FETCH/DECODE/EXEC/MEM/WB sequencer around PC, IR,
// A, B, ALUOut, MDR and a register file, with one shared req/ready memory port.
// Ports:
//   clk, reset           : clock, synchronous active-low reset
//   memtoreg..alucontrol : control bits from the external decoder (decodes instr)
//   mem                  : memory master port (req/we/addr/wdata out, rdata/ready in)
//   instr, pc, state     : IR contents, program counter, sequencer state
//   zero                 : combinational ALU result == 0
//   dbg_addr, dbg_data   : combinational register-file debug read
module multicycle_datapath #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned REGBITS = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 memtoreg,
    input  logic                 memread,
    input  logic                 memwrite,
    input  logic                 branch,
    input  logic                 jump,
    input  logic                 alusrc,
    input  logic                 regdst,
    input  logic                 regwrite,
    input  logic [2:0]           alucontrol,
    multicycle_datapath_if.master mem,
    output logic [31:0]          instr,
    output logic [WIDTH-1:0]     pc,
    output logic [2:0]           state,
    output logic                 zero,
    input  logic [REGBITS-1:0]   dbg_addr,
    output logic [WIDTH-1:0]     dbg_data
);
    localparam int unsigned NREGS = 2 ** REGBITS;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [31:0]      ir_q, ir_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] aluout_q, aluout_d, mdr_q, mdr_d;
    // Low for the first cycle after reset so a pending request drops immediately.
    logic             run_q;

    logic [WIDTH-1:0] rf [NREGS];

    logic [REGBITS-1:0] ra_c, rb_c, wa_c;
    logic [WIDTH-1:0]   rfa_c, rfb_c, wdata_c;
    logic [WIDTH-1:0]   signimm_c, srcb_c, alu_c;
    logic               rf_we_c, acc_done_c;

    // Field decode; REGBITS'() truncates (or widens) the 5-bit register fields.
    assign ra_c      = REGBITS'(ir_q[25:21]);
    assign rb_c      = REGBITS'(ir_q[20:16]);
    assign wa_c      = regdst ? REGBITS'(ir_q[15:11]) : rb_c;
    assign wdata_c   = memtoreg ? mdr_q : aluout_q;
    assign signimm_c = {{(WIDTH-16){ir_q[15]}}, ir_q[15:0]};
    assign srcb_c    = alusrc ? signimm_c : b_q;

    // r0 reads as zero regardless of array contents.
    assign rfa_c    = (ra_c == '0) ? '0 : rf[ra_c];
    assign rfb_c    = (rb_c == '0) ? '0 : rf[rb_c];
    assign dbg_data = (dbg_addr == '0) ? '0 : rf[dbg_addr];

    // ALU
    always_comb begin
        alu_c = '0;
        case (alucontrol)
            3'b010:  alu_c = a_q + srcb_c;
            3'b110:  alu_c = a_q - srcb_c;
            3'b000:  alu_c = a_q & srcb_c;
            3'b001:  alu_c = a_q | srcb_c;
            3'b111:  alu_c = WIDTH'($signed(a_q) < $signed(srcb_c));
            default: alu_c = '0;
        endcase
    end
    assign zero = (alu_c == '0);

    // Memory port: only FETCH and MEM request; addr/we/wdata come from flops so they hold.
    assign mem.mem_req   = run_q && ((state_q == S_FETCH) || (state_q == S_MEM));
    assign mem.mem_we    = (state_q == S_MEM) && memwrite;
    assign mem.mem_addr  = (state_q == S_MEM) ? aluout_q : pc_q;
    assign mem.mem_wdata = b_q;
    assign acc_done_c    = mem.mem_req && mem.mem_ready;

    assign instr = ir_q;
    assign pc    = pc_q;
    assign state = state_q;

    // Sequencer next-state and datapath register updates
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        aluout_d = aluout_q;
        mdr_d    = mdr_q;
        rf_we_c  = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (acc_done_c) begin
                    ir_d    = mem.mem_rdata[31:0];
                    pc_d    = pc_q + WIDTH'(1);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d     = rfa_c;
                b_d     = rfb_c;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                aluout_d = alu_c;
                if (jump) begin
                    pc_d    = {pc_q[WIDTH-1:26], ir_q[25:0]};
                    state_d = S_FETCH;
                end else if (branch) begin
                    if (zero) pc_d = pc_q + signimm_c;
                    state_d = S_FETCH;
                end else if (memread || memwrite) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (acc_done_c) begin
                    if (memwrite) begin
                        state_d = S_FETCH;
                    end else begin
                        mdr_d   = mem.mem_rdata;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we_c = regwrite;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Architectural state registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_FETCH;
            pc_q     <= '0;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
            mdr_q    <= '0;
            run_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            a_q      <= a_d;
            b_q      <= b_d;
            aluout_q <= aluout_d;
            mdr_q    <= mdr_d;
            run_q    <= 1'b1;
        end
    end

    // Register file: not reset; a reset edge suppresses the write.
    always_ff @(posedge clk) begin
        if (reset && rf_we_c && (wa_c != '0)) begin
            rf[wa_c] <= wdata_c;
        end
    end
endmodule

// File: tb/tb_multicycle_datapath.sv
// Bench for multicycle_datapath: a small program in a behavioural memory with
// configurable wait states, a bench-side instruction decoder, and a scoreboard of
// expected memory accesses checked by an independent monitor.
module tb_multicycle_datapath;
    localparam int unsigned WIDTH   = 32;
    localparam int unsigned REGBITS = 5;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic              memtoreg, memread, memwrite, branch, jump, alusrc, regdst, regwrite;
    logic [2:0]        alucontrol;
    logic [31:0]       instr;
    logic [WIDTH-1:0]  pc;
    logic [2:0]        state;
    logic              zero;
    logic [REGBITS-1:0] dbg_addr = '0;
    logic [WIDTH-1:0]  dbg_data;

    multicycle_datapath_if #(.WIDTH(WIDTH)) bus ();

    multicycle_datapath #(.WIDTH(WIDTH), .REGBITS(REGBITS)) dut (
        .clk        (clk),
        .reset      (reset),
        .memtoreg   (memtoreg),
        .memread    (memread),
        .memwrite   (memwrite),
        .branch     (branch),
        .jump       (jump),
        .alusrc     (alusrc),
        .regdst     (regdst),
        .regwrite   (regwrite),
        .alucontrol (alucontrol),
        .mem        (bus.master),
        .instr      (instr),
        .pc         (pc),
        .state      (state),
        .zero       (zero),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    // External decoder model driven from the registered IR.
    always_comb begin
        memtoreg = 1'b0; memread = 1'b0; memwrite = 1'b0; branch = 1'b0;
        jump = 1'b0; alusrc = 1'b0; regdst = 1'b0; regwrite = 1'b0;
        alucontrol = 3'b010;
        case (instr[31:26])
            6'h00: begin
                regdst = 1'b1; regwrite = 1'b1;
                case (instr[5:0])
                    6'h20: alucontrol = 3'b010;
                    6'h22: alucontrol = 3'b110;
                    6'h24: alucontrol = 3'b000;
                    6'h25: alucontrol = 3'b001;
                    6'h2a: alucontrol = 3'b111;
                    default: alucontrol = 3'b011;
                endcase
            end
            6'h23: begin memread = 1'b1; alusrc = 1'b1; regwrite = 1'b1; memtoreg = 1'b1; end
            6'h2b: begin memwrite = 1'b1; alusrc = 1'b1; end
            6'h04: begin branch = 1'b1; alucontrol = 3'b110; end
            6'h02: jump = 1'b1;
            6'h08: begin alusrc = 1'b1; regwrite = 1'b1; end
            default: ;
        endcase
    end

    // Behavioural memory with wait_cycles not-ready cycles per access.
    logic [31:0] mem [512];
    int wait_cycles = 0;
    int wait_cnt    = 0;

    always @(negedge clk) begin
        if (bus.mem_req === 1'b1 && wait_cnt >= wait_cycles) begin
            bus.mem_ready = 1'b1;
            bus.mem_rdata = mem[bus.mem_addr[8:0]];
        end else begin
            bus.mem_ready = 1'b0;
            bus.mem_rdata = '0;
        end
    end

    always @(posedge clk) begin
        if (bus.mem_req === 1'b1 && bus.mem_ready === 1'b1) begin
            if (bus.mem_we === 1'b1) mem[bus.mem_addr[8:0]] = bus.mem_wdata;
            wait_cnt = 0;
        end else if (bus.mem_req === 1'b1) begin
            wait_cnt = wait_cnt + 1;
        end else begin
            wait_cnt = 0;
        end
    end

    // Scoreboard
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } acc_t;

    acc_t exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_f(input logic [31:0] addr);
        acc_t e;
        e.we = 1'b0; e.addr = addr; e.wdata = '0;
        exp_q.push_back(e);
    endtask

    task automatic push_m(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        acc_t e;
        e.we = we; e.addr = addr; e.wdata = wdata;
        exp_q.push_back(e);
    endtask

    // Monitor: a new access is a requesting cycle with no wait cycles yet counted.
    logic        last_we;
    logic [31:0] last_addr, last_wdata;
    always @(negedge clk) begin
        acc_t e;
        if (bus.mem_req === 1'b1) begin
            if (wait_cnt == 0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL acc_unexpected: got access addr %h we %b, required none",
                             bus.mem_addr, bus.mem_we);
                end else begin
                    e = exp_q.pop_front();
                    chk("acc_we", 32'(bus.mem_we), 32'(e.we));
                    chk("acc_addr", bus.mem_addr, e.addr);
                    if (e.we) chk("acc_wdata", bus.mem_wdata, e.wdata);
                end
                last_we    = bus.mem_we;
                last_addr  = bus.mem_addr;
                last_wdata = bus.mem_wdata;
            end else begin
                chk("hold_addr", bus.mem_addr, last_addr);
                chk("hold_we", 32'(bus.mem_we), 32'(last_we));
                chk("hold_wdata", bus.mem_wdata, last_wdata);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reg(input int r, input logic [31:0] exp);
        dbg_addr = REGBITS'(r);
        #1;
        chk($sformatf("reg_r%0d", r), dbg_data, exp);
    endtask

    // Runs from the current FETCH cycle until FETCH is re-entered, counting cycles.
    task automatic run_instr(input string name, input int exp_cycles);
        int n = 0;
        do begin
            step();
            n++;
        end while (state != 3'd0 && n < 60);
        chk({name, "_cycles"}, 32'(n), 32'(exp_cycles));
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 32'h0;
        mem[0]     = 32'h20010005; // addi r1,r0,5
        mem[1]     = 32'h20020007; // addi r2,r0,7
        mem[2]     = 32'h00221820; // add  r3,r1,r2
        mem[3]     = 32'hAC030040; // sw   r3,0x40(r0)
        mem[4]     = 32'h8C040040; // lw   r4,0x40(r0)
        mem[5]     = 32'h00413022; // sub  r6,r2,r1
        mem[6]     = 32'h200AFFFD; // addi r10,r0,-3
        mem[7]     = 32'h0141582A; // slt  r11,r10,r1
        mem[8]     = 32'h00224025; // or   r8,r1,r2
        mem[9]     = 32'h00224824; // and  r9,r1,r2
        mem[10]    = 32'h1021FFFE; // beq  r1,r1,-2
        mem[11]    = 32'h00220020; // add  r0,r1,r2
        mem[12]    = 32'h08000020; // j    0x20
        mem[32'h20] = 32'h08000123; // j   0x123
        mem[32'h123] = 32'h8C040041; // lw r4,0x41(r0)
        mem[32'h41] = 32'hDEADBEEF;

        push_f(32'h0);
        repeat (2) step();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_req", 32'(bus.mem_req), 32'd0);
        chk("rst_ir", instr, 32'h0);

        reset = 1'b1;
        step();
        chk("rel_state", 32'(state), 32'd0);
        chk("rel_pc", pc, 32'h0);
        chk("rel_req", 32'(bus.mem_req), 32'd1);
        chk("rel_addr", bus.mem_addr, 32'h0);
        chk("rel_we", 32'(bus.mem_we), 32'd0);

        run_instr("addi_r1", 4);
        check_reg(1, 32'd5);
        chk("pc_after_addi", pc, 32'd1);
        push_f(32'd1);
        run_instr("addi_r2", 4);
        check_reg(2, 32'd7);

        // add with a 3-cycle fetch wait
        push_f(32'd2);
        wait_cycles = 3;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wait_state", 32'(state), 32'd0);
            chk("wait_addr", bus.mem_addr, 32'd2);
            chk("wait_ir", instr, 32'h20020007);
        end
        step();
        wait_cycles = 0;
        chk("add_ir", instr, 32'h00221820);
        chk("add_pc", pc, 32'd3);
        repeat (2) step();
        check_reg(3, 32'h0);
        step();
        chk("add_done_state", 32'(state), 32'd0);
        check_reg(3, 32'd12);

        push_f(32'd3); push_m(1'b1, 32'h40, 32'd12);
        run_instr("sw", 4);
        chk("sw_mem", mem[32'h40], 32'd12);
        push_f(32'd4); push_m(1'b0, 32'h40, 32'h0);
        run_instr("lw", 5);
        check_reg(4, 32'd12);

        push_f(32'd5); run_instr("sub", 4);  check_reg(6, 32'd2);
        push_f(32'd6); run_instr("addi_neg", 4); check_reg(10, 32'hFFFFFFFD);
        push_f(32'd7); run_instr("slt", 4);  check_reg(11, 32'd1);
        push_f(32'd8); run_instr("or", 4);   check_reg(8, 32'd7);
        push_f(32'd9); run_instr("and", 4);  check_reg(9, 32'd5);

        push_f(32'd10); run_instr("beq_taken", 3);
        chk("beq_taken_pc", pc, 32'd9);
        mem[10] = 32'h1022FFFE; // beq r1,r2,-2
        push_f(32'd9);  run_instr("and_again", 4);
        push_f(32'd10); run_instr("beq_not_taken", 3);
        chk("beq_nt_pc", pc, 32'd11);

        push_f(32'd11); run_instr("add_r0", 4);
        check_reg(0, 32'h0);
        push_f(32'd12); run_instr("j_20", 3);
        chk("j_20_pc", pc, 32'h20);
        push_f(32'h20); run_instr("j_123", 3);
        chk("j_123_pc", pc, 32'h123);

        // lw interrupted by reset while its MEM access waits
        push_f(32'h123); push_m(1'b0, 32'h41, 32'h0);
        step();
        wait_cycles = 5;
        chk("lwr_decode", 32'(state), 32'd1);
        repeat (2) step();
        chk("lwr_mem_state", 32'(state), 32'd3);
        chk("lwr_mem_req", 32'(bus.mem_req), 32'd1);
        step();
        chk("lwr_mem_wait", 32'(state), 32'd3);
        reset = 1'b0;
        step();
        chk("lwr_req_drop", 32'(bus.mem_req), 32'd0);
        chk("lwr_state", 32'(state), 32'd0);
        chk("lwr_pc", pc, 32'h0);
        check_reg(4, 32'd12);

        reset = 1'b1;
        wait_cycles = 0;
        push_f(32'h0);
        step();
        chk("restart_req", 32'(bus.mem_req), 32'd1);
        chk("restart_addr", bus.mem_addr, 32'h0);
        repeat (2) step();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
